// File: rtl/arb_pkg.sv
// Shared definitions for the request one-hot arbiter: default sizes and FSM states.
package arb_pkg;

  // Default number of request lines (the downstream 8:3 encoder needs 8)
  localparam int ARB_N     = 8;
  // Default width of the saturating coalesce counter
  localparam int ARB_CNT_W = 8;

  // IDLE: nothing offered; OFFER: a grant is held on the output until accepted
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/req_onehot_arbiter_rr_pick.sv
// Rotating first-one finder: returns a one-hot grant for the first set bit of i_vec
// scanning upward from i_ptr with wrap-around. With i_rr_en low the scan always
// starts at bit 0, giving fixed lowest-index priority.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vec,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_rr_en,
  output logic [N-1:0]     o_grant
);

  logic             w_found;
  int               w_start;
  logic [PTR_W-1:0] w_idx;

  // Walk the N positions in rotated order and keep only the first hit
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_start = i_rr_en ? int'(i_ptr) : 0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((w_start + k) % N);
      if (!w_found && i_vec[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Request capture and arbitration stage ahead of the 8:3 priority encoder.
// Request pulses are latched into sticky pending bits; one of them is offered as a
// registered one-hot word under a valid/ready handshake. The offered word is frozen
// until accepted, and the output is never zero-hot or multi-hot while valid_out=1.
module req_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N           = ARB_N,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int CNT_W       = ARB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [N-1:0]     onehot_out,
  output logic [N-1:0]     pending_out,
  output logic [CNT_W-1:0] coalesce_cnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  // Registered state
  arb_state_e       r_state;
  logic             r_valid;
  logic [N-1:0]     r_onehot;
  logic [N-1:0]     r_pending;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  // Combinational helpers
  logic             w_accept;
  logic [N-1:0]     w_acc_mask;
  logic [N-1:0]     w_pend_next;
  logic [N-1:0]     w_rem;
  logic             w_coalesce;
  logic [PTR_W-1:0] w_grant_idx;
  logic [PTR_W-1:0] w_ptr_next;
  logic [N-1:0]     w_pick_vec;
  logic [PTR_W-1:0] w_pick_ptr;
  logic [N-1:0]     w_pick;

  // Binary index of a one-hot word (the offered grant is always one-hot in OFFER)
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  assign w_accept    = r_valid & ready_in;
  assign w_acc_mask  = w_accept ? r_onehot : '0;
  // Set wins over clear: a request on the bit being accepted re-arms it
  assign w_pend_next = (r_pending & ~w_acc_mask) | req_in;
  // At most one count per cycle, however many bits coalesce
  assign w_coalesce  = |(req_in & r_pending & ~w_acc_mask);
  // Requests still waiting once the current grant is taken; same-cycle req_in excluded
  assign w_rem       = r_pending & ~r_onehot;

  assign w_grant_idx = onehot_idx(r_onehot);
  assign w_ptr_next  = (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + 1'b1;

  // A single finder serves both cases: fresh pick from pending in IDLE, or the
  // back-to-back pick from the remainder, scanning from just after the grant being accepted
  assign w_pick_vec  = (r_state == OFFER) ? w_rem      : r_pending;
  assign w_pick_ptr  = (r_state == OFFER) ? w_ptr_next : r_ptr;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_vec   (w_pick_vec),
    .i_ptr   (w_pick_ptr),
    .i_rr_en (ROUND_ROBIN),
    .o_grant (w_pick)
  );

  // Offer FSM: load a grant from IDLE, hold it under backpressure, chain on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_onehot <= w_pick;
            r_valid  <= 1'b1;
            r_state  <= OFFER;
          end
        end
        OFFER: begin
          if (w_accept) begin
            r_ptr <= w_ptr_next;
            if (|w_rem) begin
              r_onehot <= w_pick;
            end else begin
              r_onehot <= '0;
              r_valid  <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_valid  <= 1'b0;
          r_onehot <= '0;
        end
      endcase
    end
  end

  // Sticky pending vector: cleared only by acceptance of its bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_next;
    end
  end

  // Saturating count of requests that landed on an already-pending line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_coalesce && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign valid_out    = r_valid;
  assign onehot_out   = r_onehot;
  assign pending_out  = r_pending;
  assign coalesce_cnt = r_cnt;

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Scoreboard bench for req_onehot_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural request/grant model.
module tb_req_onehot_arbiter;

  localparam int N  = 8;
  localparam bit RR = 1'b1;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic       ready_in;
  logic       valid_out;
  logic [7:0] onehot_out;
  logic [7:0] pending_out;
  logic [7:0] coalesce_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit [7:0] m_pend  = '0;
  bit       m_valid = 1'b0;
  int       m_idx   = 0;
  int       m_ptr   = 0;
  int       m_cnt   = 0;
  bit       mon_en  = 1'b0;

  logic [7:0] exp_q[$];

  req_onehot_arbiter #(
    .N           (N),
    .ROUND_ROBIN (RR),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .onehot_out   (onehot_out),
    .pending_out  (pending_out),
    .coalesce_cnt (coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_grant();
    return m_valid ? (8'b1 << m_idx) : 8'h00;
  endfunction

  // First pending request in priority order, -1 if none
  function automatic int m_pick(input bit [7:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = RR ? (ptr + k) % N : k;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge
  task automatic model_step(input bit [7:0] req, input bit rdy, input bit rs);
    bit       acc;
    int       aidx;
    bit [7:0] old_p;
    bit [7:0] rem;
    bit       hit;
    int       p;
    if (rs) begin
      m_pend = '0; m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      return;
    end
    acc   = m_valid && rdy;
    aidx  = m_idx;
    old_p = m_pend;
    hit   = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && old_p[i] && !(acc && i == aidx)) hit = 1;
    end
    if (hit && m_cnt < 255) m_cnt++;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = (old_p[i] && !(acc && i == aidx)) || req[i];
    end
    if (!m_valid) begin
      p = m_pick(old_p, m_ptr);
      if (p >= 0) begin m_idx = p; m_valid = 1; end
    end else if (acc) begin
      m_ptr = (aidx + 1) % N;
      rem = old_p;
      rem[aidx] = 1'b0;
      p = m_pick(rem, m_ptr);
      if (p >= 0) m_idx = p;
      else m_valid = 0;
    end
  endtask

  // Drive one cycle of stimulus; an accept predicted for the coming edge is queued
  task automatic cycle(input logic [7:0] req, input bit rdy, input bit rs);
    req_in   = req;
    ready_in = rdy;
    rst      = rs;
    if (m_valid && rdy && !rs) exp_q.push_back(m_grant());
    @(posedge clk);
    model_step(req, rdy, rs);
    #1;
  endtask

  // Monitor: invariants, status compare and scoreboard pop on each accept
  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (mon_en) begin
      if (valid_out) chk("onehot_valid", 32'($onehot(onehot_out)), 32'd1);
      else           chk("zero_when_idle", 32'(onehot_out), 32'd0);
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("onehot_out", 32'(onehot_out), 32'(m_grant()));
      chk("pending_out", 32'(pending_out), 32'(m_pend));
      chk("coalesce_cnt", 32'(coalesce_cnt), 32'(m_cnt));
      if (valid_out && ready_in && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL grant_unexpected actual=%0h required=none at %0t", onehot_out, $time);
        end else begin
          exp_v = exp_q.pop_front();
          chk("grant_accepted", 32'(onehot_out), 32'(exp_v));
        end
      end
    end
  end

  initial begin
    req_in = '0; ready_in = 1'b0; rst = 1'b1;
    cycle(8'h00, 0, 1);
    mon_en = 1'b1;
    cycle(8'h00, 0, 1);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_cnt", 32'(coalesce_cnt), 32'd0);

    // Single pulse: valid two edges later
    cycle(8'h04, 0, 0);
    chk("lat_edge1_valid", 32'(valid_out), 32'd0);
    cycle(8'h00, 0, 0);
    chk("lat_edge2_grant", 32'(onehot_out), 32'h04);
    cycle(8'h00, 1, 0);
    chk("drop_after_accept", 32'(valid_out), 32'd0);

    // Round robin back-to-back from a fresh pointer
    cycle(8'h00, 0, 1);
    cycle(8'h81, 1, 0);
    cycle(8'h00, 1, 0);
    chk("rr_first", 32'(onehot_out), 32'h01);
    cycle(8'h00, 1, 0);
    chk("rr_second", 32'(onehot_out), 32'h80);
    cycle(8'h00, 1, 0);
    chk("rr_done", 32'(valid_out), 32'd0);
    cycle(8'h00, 1, 0);

    // Backpressure holds the offered grant
    cycle(8'h00, 0, 1);
    cycle(8'h10, 0, 0);
    cycle(8'h00, 0, 0);
    cycle(8'h01, 0, 0);
    for (int i = 0; i < 10; i++) cycle(8'h00, 0, 0);
    chk("bp_hold", 32'(onehot_out), 32'h10);
    for (int i = 0; i < 4; i++) cycle(8'h00, 1, 0);

    // Set wins on the accept edge
    cycle(8'h00, 0, 1);
    cycle(8'h02, 0, 0);
    cycle(8'h00, 0, 0);
    cycle(8'h02, 1, 0);
    cycle(8'h00, 0, 0);
    chk("setwin_regrant", 32'(onehot_out), 32'h02);
    chk("setwin_cnt", 32'(coalesce_cnt), 32'd0);
    cycle(8'h00, 1, 0);

    // Coalesce counter saturation
    cycle(8'h00, 0, 1);
    for (int i = 0; i < 300; i++) cycle(8'h08, 0, 0);
    chk("coal_sat", 32'(coalesce_cnt), 32'd255);
    for (int i = 0; i < 3; i++) cycle(8'h00, 1, 0);

    // Reset in the middle of an offer
    cycle(8'h00, 0, 1);
    cycle(8'h60, 0, 0);
    cycle(8'h00, 0, 0);
    chk("mid_offer_grant", 32'(onehot_out), 32'h20);
    chk("mid_offer_pend", 32'(pending_out), 32'h60);
    cycle(8'h00, 1, 1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pend", 32'(pending_out), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cycle(r, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(8'h00, 1, 0);
    chk("drain_valid", 32'(valid_out), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
